// File: rtl/cpu_defs.sv
// Shared constants for the CPU memory path: access-controller state encodings and
// the rw encoding used by the control unit.
package cpu_defs;

    typedef enum logic [1:0] {
        MAC_IDLE   = 2'd0,
        MAC_ACCESS = 2'd1,
        MAC_WAIT   = 2'd2,
        MAC_DONE   = 2'd3
    } mac_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with zero flag; times the RAM read latency window.
module mem_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-word RAM access sequencer between the MDR memory side and synchronous RAM.
// All outputs are registered; read data lands in rdata on the edge that ends the wait window.
module mem_access_ctrl
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req,
    input  logic                  rw,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mdr_load,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int             CW        = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0]  WAIT_LOAD = CW'(WAIT_CYCLES - 1);

    mac_state_t state;
    logic       rw_q;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
    logic       out_of_range;

    assign out_of_range = (addr[31:ADDR_WIDTH] != '0);
    assign cnt_load     = (state == MAC_ACCESS) && (rw_q == RW_READ);
    assign cnt_dec      = (state == MAC_WAIT) && !cnt_zero;

    mem_wait_counter #(.WIDTH(CW)) u_wait (
        .clock    (clock),
        .clear    (clear),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= MAC_IDLE;
            rw_q      <= RW_WRITE;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            mdr_load  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises only what it owns.
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            done     <= 1'b0;
            mdr_load <= 1'b0;
            case (state)
                MAC_IDLE: begin
                    if (req) begin
                        rw_q      <= rw;
                        ram_addr  <= addr[ADDR_WIDTH-1:0];
                        ram_wdata <= wdata;
                        fault     <= out_of_range;
                        busy      <= 1'b1;
                        if (out_of_range) begin
                            state <= MAC_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= MAC_ACCESS;
                            if (rw == RW_READ) ram_re <= 1'b1;
                            else               ram_we <= 1'b1;
                        end
                    end
                end
                MAC_ACCESS: begin
                    if (rw_q == RW_READ) begin
                        state <= MAC_WAIT;
                    end else begin
                        state <= MAC_DONE;
                        done  <= 1'b1;
                    end
                end
                MAC_WAIT: begin
                    if (cnt_zero) begin
                        rdata    <= ram_rdata;
                        state    <= MAC_DONE;
                        done     <= 1'b1;
                        mdr_load <= 1'b1;
                    end
                end
                MAC_DONE: begin
                    state <= MAC_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= MAC_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (read latency 1 and 3) share stimulus, each
// checked every cycle against a transaction-timeline model, plus literal directed checks.
module tb_mem_access_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 9;
    localparam int NDUT = 2;

    logic clock = 1'b0;
    logic clear, req, rw;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;

    logic [NDUT-1:0][DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [NDUT-1:0][AW-1:0] ram_addr;
    logic [NDUT-1:0]         mdr_load, busy, done, fault, ram_we, ram_re;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_access_ctrl #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .WAIT_CYCLES(g == 0 ? 1 : 3)
        ) u_dut (
            .clock     (clock),
            .clear     (clear),
            .req       (req),
            .rw        (rw),
            .addr      (addr),
            .wdata     (wdata),
            .rdata     (rdata[g]),
            .mdr_load  (mdr_load[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .fault     (fault[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_we    (ram_we[g]),
            .ram_re    (ram_re[g]),
            .ram_rdata (ram_rdata[g])
        );
    end

    function automatic int wlat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    int cyc = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // RAM models: data appears exactly WAIT_CYCLES cycles after the re cycle, junk otherwise
    logic [DW-1:0] ram_m   [NDUT][512];
    logic [DW-1:0] rd_pipe [NDUT][3];
    assign ram_rdata[0] = rd_pipe[0][0];
    assign ram_rdata[1] = rd_pipe[1][2];

    initial begin
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 512; i++) ram_m[k][i] = init_word(i);
        forever begin
            @(posedge clock);
            for (int k = 0; k < NDUT; k++) begin
                if (ram_we[k]) ram_m[k][ram_addr[k]] = ram_wdata[k];
                rd_pipe[k][0] <= ram_re[k] ? ram_m[k][ram_addr[k]] : $urandom;
                rd_pipe[k][1] <= rd_pipe[k][0];
                rd_pipe[k][2] <= rd_pipe[k][1];
            end
        end
    end

    // Reference model: each accepted request schedules its strobe/done/load cycles up front
    bit            live = 1'b0;
    int            acc_c [NDUT], we_c [NDUT], re_c [NDUT], done_c [NDUT], load_c [NDUT];
    logic          e_fault [NDUT];
    logic [31:0]   e_rdata [NDUT], pend [NDUT], e_rwdata [NDUT];
    logic [AW-1:0] e_raddr [NDUT];
    logic [31:0]   ref_mem [NDUT][512];

    function automatic bit m_busy(input int k, input int c);
        return (acc_c[k] >= 0) && (c > acc_c[k]) && (c <= done_c[k]);
    endfunction

    task automatic m_reset(input int k);
        acc_c[k] = -1; we_c[k] = -1; re_c[k] = -1; done_c[k] = -1; load_c[k] = -1;
        e_fault[k] = 1'b0; e_rdata[k] = '0; pend[k] = '0; e_rwdata[k] = '0; e_raddr[k] = '0;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            m_reset(k);
            for (int i = 0; i < 512; i++) ref_mem[k][i] = init_word(i);
        end
        forever begin
            @(posedge clock);
            for (int k = 0; k < NDUT; k++) begin
                if (clear) begin
                    m_reset(k);
                end else begin
                    if (load_c[k] == cyc + 1) e_rdata[k] = pend[k];
                    if (req && !m_busy(k, cyc)) begin
                        acc_c[k] = cyc; we_c[k] = -1; re_c[k] = -1; load_c[k] = -1;
                        e_raddr[k]  = addr[AW-1:0];
                        e_rwdata[k] = wdata;
                        e_fault[k]  = (addr >> AW) != 0;
                        if (e_fault[k]) begin
                            done_c[k] = cyc + 1;
                        end else if (!rw) begin
                            we_c[k]   = cyc + 1;
                            done_c[k] = cyc + 2;
                            ref_mem[k][addr[AW-1:0]] = wdata;
                        end else begin
                            re_c[k]   = cyc + 1;
                            done_c[k] = cyc + wlat(k) + 2;
                            load_c[k] = done_c[k];
                            pend[k]   = ref_mem[k][addr[AW-1:0]];
                        end
                    end
                end
            end
            cyc++;
            live = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (live) begin
                for (int k = 0; k < NDUT; k++) begin
                    chk("busy",      k, 32'(busy[k]),      32'(m_busy(k, cyc)));
                    chk("done",      k, 32'(done[k]),      32'(done_c[k] == cyc));
                    chk("mdr_load",  k, 32'(mdr_load[k]),  32'(load_c[k] == cyc));
                    chk("ram_we",    k, 32'(ram_we[k]),    32'(we_c[k] == cyc));
                    chk("ram_re",    k, 32'(ram_re[k]),    32'(re_c[k] == cyc));
                    chk("fault",     k, 32'(fault[k]),     32'(e_fault[k]));
                    chk("rdata",     k, rdata[k],          e_rdata[k]);
                    chk("ram_addr",  k, 32'(ram_addr[k]),  32'(e_raddr[k]));
                    chk("ram_wdata", k, ram_wdata[k],      e_rwdata[k]);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy != '0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", 0, 32'(busy), 32'd0);
    endtask

    // Returns #1 into cycle 1 (the cycle after the accepting edge)
    task automatic start(input logic r, input logic [31:0] a, input logic [31:0] d);
        wait_idle();
        req = 1'b1; rw = r; addr = a; wdata = d;
        @(posedge clock); #1;
        req = 1'b0;
    endtask

    int re_n, done_n;

    initial begin
        clear = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_busy",  k, 32'(busy[k]),     32'd0);
            chk("rst_rdata", k, rdata[k],         32'd0);
            chk("rst_raddr", k, 32'(ram_addr[k]), 32'd0);
        end
        @(posedge clock); #1;
        clear = 1'b0;

        // write 0xDEADBEEF to 0x055
        start(1'b0, 32'h0000_0055, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("t1_we",    0, 32'(ram_we[0]),    32'd1);
        chk("t1_addr",  0, 32'(ram_addr[0]),  32'h055);
        chk("t1_wdata", 0, ram_wdata[0],      32'hDEAD_BEEF);
        chk("t1_we",    1, 32'(ram_we[1]),    32'd1);
        @(negedge clock);
        chk("t1_done",  0, 32'(done[0]),      32'd1);
        chk("t1_fault", 0, 32'(fault[0]),     32'd0);

        // read back: latency 1 completes cycle 3, latency 3 completes cycle 5
        start(1'b1, 32'h0000_0055, 32'h0);
        @(negedge clock);
        chk("t2_re", 0, 32'(ram_re[0]), 32'd1);
        chk("t3_re", 1, 32'(ram_re[1]), 32'd1);
        repeat (2) @(negedge clock);
        chk("t2_done",  0, 32'(done[0]),     32'd1);
        chk("t2_load",  0, 32'(mdr_load[0]), 32'd1);
        chk("t2_rdata", 0, rdata[0],         32'hDEAD_BEEF);
        repeat (2) @(negedge clock);
        chk("t3_done",  1, 32'(done[1]),     32'd1);
        chk("t3_load",  1, 32'(mdr_load[1]), 32'd1);
        chk("t3_rdata", 1, rdata[1],         32'hDEAD_BEEF);

        // out-of-range read faults immediately; next good request clears it
        start(1'b1, 32'h0000_0200, 32'h0);
        @(negedge clock);
        chk("t4_done",  0, 32'(done[0]),     32'd1);
        chk("t4_fault", 0, 32'(fault[0]),    32'd1);
        chk("t4_load",  0, 32'(mdr_load[0]), 32'd0);
        chk("t4_re",    0, 32'(ram_re[0]),   32'd0);
        start(1'b0, 32'h0000_0010, 32'h0000_1234);
        @(negedge clock);
        chk("t4_clr",   0, 32'(fault[0]),    32'd0);

        // requests while busy are dropped
        start(1'b1, 32'h0000_0055, 32'h0);
        req = 1'b1; rw = 1'b0; addr = 32'h0000_0077; wdata = 32'hCAFE_0001;
        re_n = 0; done_n = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            re_n   += 32'(ram_re[1]);
            done_n += 32'(done[1]);
            @(posedge clock); #1;
            if (c == 2) req = 1'b0;
        end
        chk("t5_re_count",   1, re_n,   32'd1);
        chk("t5_done_count", 1, done_n, 32'd1);
        start(1'b0, 32'h0000_0033, 32'h0BAD_F00D);
        @(negedge clock);
        chk("t5_accept", 1, 32'(ram_we[1]), 32'd1);

        // clear during the wait window discards the read
        start(1'b1, 32'h0000_0055, 32'h0);
        @(posedge clock); #1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        @(negedge clock);
        for (int k = 0; k < NDUT; k++) begin
            chk("t6_busy",  k, 32'(busy[k]), 32'd0);
            chk("t6_done",  k, 32'(done[k]), 32'd0);
            chk("t6_rdata", k, rdata[k],     32'd0);
        end

        // randomized traffic, mostly in a small address window so reads hit prior writes
        for (int n = 0; n < 1500; n++) begin
            @(posedge clock); #1;
            clear = ($urandom_range(0, 99) == 0);
            req   = ($urandom_range(0, 2) == 0);
            rw    = 1'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0)      addr = $urandom | 32'h0000_0200;
            else if ($urandom_range(0, 1) == 0) addr = 32'($urandom_range(0, 15));
            else                                addr = 32'($urandom_range(0, 511));
        end
        @(posedge clock); #1;
        clear = 1'b0; req = 1'b0;
        repeat (20) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
